// File: rtl/envelope_feeder.sv
// Envelope feeder: converts strobed ADC samples, buffers them in a FIFO and presents them to a filter with Rdy/Ack.
// Build option: define ENV_RECTIFY_EN for full-wave rectification; otherwise samples are converted to offset binary.
module envelope_feeder #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   AdcData,
    input  logic          AdcStrobe,
    input  logic          Ack,
    input  logic          ClrOvf,
    output logic [15:0]   DataOut,
    output logic          Rdy,
    output logic          Overflow,
    output logic [AW:0]   Level
);

    localparam int unsigned DW = 16;
    localparam int unsigned LW = AW + 1;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DW-1:0]     data_q, data_d;
    logic              rdy_q, rdy_d;
    logic              ovf_q, ovf_d;

    logic [DW-1:0]     conv_c;
    logic              full_c;
    logic              empty_c;
    logic              pop_c;
    logic              wr_c;
    logic              drop_c;

    // Sample conversion, applied in the strobe cycle ahead of the FIFO write
`ifdef ENV_RECTIFY_EN
    always_comb begin
        conv_c = AdcData;
        if (AdcData == 16'h8000) begin
            conv_c = 16'h7FFF;
        end else if (AdcData[DW-1]) begin
            conv_c = DW'(~AdcData + 16'd1);
        end
    end
`else
    always_comb begin
        conv_c = AdcData ^ 16'h8000;
    end
`endif

    assign full_c  = (level_q == LW'(DEPTH));
    assign empty_c = (level_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!empty_c) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (Ack && empty_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        pop_c    = !empty_c && ((state_q == IDLE) || ((state_q == PRESENT) && Ack));
        wr_c     = AdcStrobe && (!full_c || pop_c);
        drop_c   = AdcStrobe && full_c && !pop_c;
        data_d   = data_q;
        rdy_d    = (state_d == PRESENT);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (pop_c) begin
            data_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (wr_c && !pop_c) begin
            level_d = level_q + LW'(1);
        end else if (pop_c && !wr_c) begin
            level_d = level_q - LW'(1);
        end
        // A drop wins over a same-cycle clear
        if (drop_c) begin
            ovf_d = 1'b1;
        end else if (ClrOvf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
            rdy_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
            rdy_q    <= rdy_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset; pointers define what is valid
    always_ff @(posedge clk) begin
        if (!reset && wr_c) begin
            mem_q[wr_ptr_q] <= conv_c;
        end
    end

    assign DataOut  = data_q;
    assign Rdy      = rdy_q;
    assign Overflow = ovf_q;
    assign Level    = level_q;

endmodule

// File: tb/tb_envelope_feeder.sv
// Self-checking bench for envelope_feeder: conversion vector table plus overflow, full-bypass and reset sequences.
module tb_envelope_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] AdcData;
    logic        AdcStrobe;
    logic        Ack;
    logic        ClrOvf;
    logic [15:0] DataOut;
    logic        Rdy;
    logic        Overflow;
    logic [3:0]  Level;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];

    typedef struct {
        logic [15:0] adc;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    envelope_feeder #(.DEPTH(8), .AW(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .AdcData  (AdcData),
        .AdcStrobe(AdcStrobe),
        .Ack      (Ack),
        .ClrOvf   (ClrOvf),
        .DataOut  (DataOut),
        .Rdy      (Rdy),
        .Overflow (Overflow),
        .Level    (Level)
    );

    function automatic logic [15:0] model_conv(input logic [15:0] x);
`ifdef ENV_RECTIFY_EN
        int v;
        v = int'($signed(x));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return 16'(v);
`else
        return x ^ 16'h8000;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic strobe(input logic [15:0] d, input bit accepted);
        AdcData   = d;
        AdcStrobe = 1'b1;
        if (accepted) sb.push_back(model_conv(d));
        tick();
        AdcStrobe = 1'b0;
    endtask

    task automatic check_present(input string nm);
        logic [15:0] e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s got=%h want=<empty scoreboard>", nm, DataOut);
        end else begin
            e = sb.pop_front();
            chk(nm, 32'(DataOut), 32'(e));
            chk({nm, "_rdy"}, 32'(Rdy), 32'd1);
        end
    endtask

    task automatic ack_once;
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
    endtask

    initial begin
`ifdef ENV_RECTIFY_EN
        vecs[0] = '{16'h0000, 16'h0000};
        vecs[1] = '{16'hFFFF, 16'h0001};
        vecs[2] = '{16'h8000, 16'h7FFF};
        vecs[3] = '{16'h7FFF, 16'h7FFF};
        vecs[4] = '{16'h1234, 16'h1234};
        vecs[5] = '{16'hFB50, 16'h04B0};
`else
        vecs[0] = '{16'h0000, 16'h8000};
        vecs[1] = '{16'hFFFF, 16'h7FFF};
        vecs[2] = '{16'h8000, 16'h0000};
        vecs[3] = '{16'h7FFF, 16'hFFFF};
        vecs[4] = '{16'h1234, 16'h9234};
        vecs[5] = '{16'hFB50, 16'h7B50};
`endif
        reset = 1'b1; AdcData = '0; AdcStrobe = 1'b0; Ack = 1'b0; ClrOvf = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_rdy",   32'(Rdy),      32'd0);
        chk("rst_level", 32'(Level),    32'd0);
        chk("rst_ovf",   32'(Overflow), 32'd0);
        chk("rst_data",  32'(DataOut),  32'd0);

        // Conversion table, single sample each, Ack three cycles after Rdy
        for (int i = 0; i < 6; i++) begin
            strobe(vecs[i].adc, 1'b0);
            chk($sformatf("v%0d_rdy_k", i),   32'(Rdy),   32'd0);
            chk($sformatf("v%0d_level_k", i), 32'(Level), 32'd1);
            tick();
            chk($sformatf("v%0d_rdy_k1", i),  32'(Rdy),     32'd1);
            chk($sformatf("v%0d_data", i),    32'(DataOut), 32'(vecs[i].exp));
            chk($sformatf("v%0d_level", i),   32'(Level),   32'd0);
            tick();
            tick();
            chk($sformatf("v%0d_hold", i),    32'(DataOut), 32'(vecs[i].exp));
            chk($sformatf("v%0d_holdrdy", i), 32'(Rdy),     32'd1);
            ack_once();
            chk($sformatf("v%0d_rdy_ack", i), 32'(Rdy),   32'd0);
            chk($sformatf("v%0d_lvl_ack", i), 32'(Level), 32'd0);
        end

        // Overflow: 10 strobes with no Ack, then drain 9
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            strobe(16'(i * 32'h1111), i <= 9);
        end
        chk("ovf_rdy",   32'(Rdy),      32'd1);
        chk("ovf_level", 32'(Level),    32'd8);
        chk("ovf_flag",  32'(Overflow), 32'd1);
        ClrOvf = 1'b1;
        strobe(16'hDEAD, 1'b0);
        ClrOvf = 1'b0;
        chk("ovf_prio",  32'(Overflow), 32'd1);
        chk("ovf_prio_level", 32'(Level), 32'd8);
        for (int j = 0; j < 9; j++) begin
            check_present($sformatf("drain%0d", j));
            ack_once();
        end
        chk("drain_rdy",   32'(Rdy),      32'd0);
        chk("drain_level", 32'(Level),    32'd0);
        chk("drain_sb",    32'(sb.size()), 32'd0);
        chk("drain_ovf",   32'(Overflow), 32'd1);
        ClrOvf = 1'b1;
        tick();
        ClrOvf = 1'b0;
        chk("clr_ovf",     32'(Overflow), 32'd0);

        // Full FIFO with simultaneous strobe and Ack
        do_reset();
        for (int i = 0; i < 9; i++) begin
            strobe(16'(32'h0100 + i), 1'b1);
        end
        chk("full_level", 32'(Level),    32'd8);
        chk("full_ovf",   32'(Overflow), 32'd0);
        check_present("full_head");
        Ack = 1'b1;
        strobe(16'h0F0F, 1'b1);
        Ack = 1'b0;
        chk("bypass_level", 32'(Level),    32'd8);
        chk("bypass_ovf",   32'(Overflow), 32'd0);
        for (int j = 0; j < 9; j++) begin
            check_present($sformatf("full_drain%0d", j));
            ack_once();
        end
        chk("full_end_rdy", 32'(Rdy), 32'd0);

        // Reset between Rdy and Ack with Level=4; strobe during reset is ignored
        do_reset();
        for (int i = 0; i < 5; i++) begin
            strobe(16'(32'h2000 + i), 1'b1);
        end
        chk("pre_rst_level", 32'(Level), 32'd4);
        chk("pre_rst_rdy",   32'(Rdy),   32'd1);
        reset = 1'b1;
        AdcStrobe = 1'b1;
        tick();
        reset = 1'b0;
        AdcStrobe = 1'b0;
        sb.delete();
        chk("mid_rst_rdy",   32'(Rdy),     32'd0);
        chk("mid_rst_level", 32'(Level),   32'd0);
        chk("mid_rst_data",  32'(DataOut), 32'd0);
        ack_once();
        chk("post_ack_rdy",   32'(Rdy),   32'd0);
        chk("post_ack_level", 32'(Level), 32'd0);
        tick();
        chk("post_ack_rdy2",  32'(Rdy),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/envelope_feeder.md
ENVELOPE_FEEDER -- requirements
Module: envelope_feeder

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set FIFO capacity in samples; legal values are powers of two, 2..64.
REQ-002 Parameter AW, default 3, SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 AdcData  input  16  signed two's-complement ADC sample.
REQ-006 AdcStrobe  input  1  one-cycle pulse; AdcData is valid in that cycle.
REQ-007 Ack  input  1  one-cycle consume pulse from downstream filter.
REQ-008 ClrOvf  input  1  clears Overflow.
REQ-009 DataOut  output  16  registered unsigned envelope sample to the filter.
REQ-010 Rdy  output  1  registered; DataOut is valid and not yet acknowledged.
REQ-011 Overflow  output  1  sticky flag: a strobed sample was dropped.
REQ-012 Level  output  AW+1  FIFO occupancy, excluding the output register.

Function
REQ-013 Conversion SHALL be applied to AdcData in the strobe cycle, before the FIFO write (see Configuration).
REQ-014 FIFO write SHALL occur on AdcStrobe when Level<DEPTH, or when Level==DEPTH and a pop occurs in the same cycle.
REQ-015 A strobe with Level==DEPTH and no same-cycle pop SHALL drop the sample, leave Level unchanged and set Overflow at that edge.
REQ-016 ClrOvf SHALL clear Overflow at the next edge; a simultaneous drop SHALL take priority and leave Overflow at 1.
REQ-017 Output FSM states: IDLE (Rdy=0) and PRESENT (Rdy=1).
REQ-018 IDLE with Level>0 SHALL pop the FIFO head into DataOut and enter PRESENT at the same edge.
REQ-019 IDLE with Level==0 SHALL remain in IDLE; Ack in IDLE SHALL be ignored.
REQ-020 PRESENT SHALL hold DataOut and Rdy stable until Ack is sampled high.
REQ-021 PRESENT with Ack and Level>0 SHALL pop the next sample into DataOut and keep Rdy=1.
REQ-022 PRESENT with Ack and Level==0 SHALL drop Rdy and enter IDLE; a same-cycle strobe is written to the FIFO, not bypassed.
REQ-023 Latency: a strobe at edge k into an empty, IDLE block SHALL produce Rdy=1 with that sample on DataOut after edge k+1.
REQ-024 Samples SHALL leave in arrival order with no duplication; read/write pointers SHALL wrap modulo DEPTH.
REQ-025 Level SHALL be +1 on write only, -1 on pop only, and unchanged when both occur.

Reset
REQ-026 When reset is high at an edge, the block SHALL clear DataOut=0, Rdy=0, Overflow=0, Level=0 and both pointers, and enter IDLE; reset SHALL override all other inputs.
REQ-027 Reset mid-operation SHALL discard buffered and presented samples; Rdy SHALL be 0 after that edge.

Configuration
REQ-028 Macro ENV_RECTIFY_EN defined: the conversion SHALL be the absolute value of AdcData, with -32768 saturating to 32767 (full-wave envelope).
REQ-029 ENV_RECTIFY_EN undefined: the conversion SHALL be offset binary, AdcData XOR 16'h8000; the interface is unchanged.

Verification
REQ-030 Rectify build, strobe AdcData=-1200, Ack 3 cycles after Rdy -> DataOut=1200 with Rdy high 2 edges after the strobe; Rdy low after the Ack edge; Level=0.
REQ-031 Rectify build, strobe -32768 then 5 -> DataOut 32767 then 5, in order.
REQ-032 Non-rectify build, strobe 16'h0000 and 16'hFFFF -> DataOut 16'h8000 then 16'h7FFF.
REQ-033 DEPTH=8, no Ack, 10 strobes -> 1 presented, Level=8, Overflow=1 after the 10th; then 9 Acks drain exactly 9 samples in order; ClrOvf clears Overflow.
REQ-034 Level=8, strobe and Ack in the same cycle -> write accepted, Level stays 8, Overflow stays 0.
REQ-035 Reset in the cycle between Rdy and Ack with Level=4 -> Rdy=0, Level=0, DataOut=0 next cycle; a later Ack has no effect.
